rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Shares the register file's single write port (wa/wda/reg_wr) between two writeback sources: the ALU/execute stage and the load/store unit (LSU).
- Arbitrates round-robin with valid/ready handshakes.
- Registers the winning write for one cycle before it reaches the register file.
- Keeps a busy scoreboard of registers with outstanding loads; the issue stage reads it to stall on load-use hazards.

Parameters:
XLEN, 32, data width of writeback values
NREG, 32, number of architectural registers (register 0 hardwired to zero)
AW, 5, register address width (log2 NREG)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU has a writeback pending
alu_ready  output  1  ALU writeback accepted this cycle
alu_rd  input  AW  ALU destination register
alu_data  input  XLEN  ALU result
lsu_valid  input  1  LSU has load data pending
lsu_ready  output  1  LSU writeback accepted this cycle
lsu_rd  input  AW  LSU destination register
lsu_data  input  XLEN  load result
iss_load  input  1  issue stage dispatches a load this cycle
iss_rd  input  AW  destination of the dispatched load
chk_ra  input  AW  source register A of the instruction in issue
chk_rb  input  AW  source register B of the instruction in issue
hazard  output  1  chk_ra or chk_rb is busy; issue must stall
wa  output  AW  register file write address (registered)
wda  output  XLEN  register file write data (registered)
reg_wr  output  1  register file write enable (registered)

Behaviour:
- Reset (reset=1 at a rising edge):
  - reg_wr=0, wa=0, wda=0.
  - All busy bits 0.
  - last_grant=ALU, so LSU wins the first contention.
- Arbitration is combinational within a cycle:
  - Only one source valid: that source is granted.
  - Both valid: the source not granted last is granted.
  - Neither valid: no grant, last_grant unchanged.
- alu_ready = grant_alu and lsu_ready = grant_lsu. Both are combinational and never 1 together.
- A transfer occurs when valid & ready are both 1. Sources hold rd/data stable until ready.
- last_grant updates only on a transfer.
- Write latency is 1 cycle. On a transfer in cycle N, in cycle N+1 reg_wr=1, wa=rd, wda=data, unless rd=0.
- Writes to rd=0:
  - The handshake completes (ready=1).
  - reg_wr=0 the next cycle; wa/wda hold their previous values.
  - last_grant still updates.
- No transfer in cycle N: reg_wr=0 in N+1; wa/wda hold their previous values.
- Fairness: a continuously valid source waits at most 1 cycle.
- Scoreboard (NREG bits):
  - iss_load=1 and iss_rd!=0: busy[iss_rd] set at the next edge.
  - LSU transfer with lsu_rd!=0: busy[lsu_rd] cleared at the next edge.
  - Set and clear to the same register in one cycle: set wins, because a new load is outstanding.
  - Set and clear to different registers in one cycle: both take effect.
- hazard is combinational: hazard = (chk_ra!=0 & busy[chk_ra]) | (chk_rb!=0 & busy[chk_rb]). There is no bypass, so hazard stays 1 through the clear cycle and drops the cycle after.
- busy[0] never sets.
- ALU writes never touch the scoreboard.
- Reset mid-operation:
  - Pending writes are dropped and reg_wr=0 the next cycle.
  - The scoreboard clears.
  - Ready outputs are forced 0 while reset=1.

Test Plan:
- Reset: reset=1 for 2 cycles with alu_valid=lsu_valid=1 -> alu_ready=lsu_ready=0, reg_wr=0, hazard=0 for every chk_ra/chk_rb.
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> alu_ready=1 the same cycle; next cycle reg_wr=1, wa=5, wda=0xDEADBEEF; the cycle after, reg_wr=0.
- Contention: both valid for 4 cycles after reset (alu_rd=1/0x11, lsu_rd=2/0x22) -> grant order LSU, ALU, LSU, ALU; wa sequence 2,1,2,1 with one cycle of lag.
- x0 write: lsu_valid=1, lsu_rd=0 -> lsu_ready=1, reg_wr stays 0, wa unchanged.
- Load-use hazard: iss_load=1, iss_rd=7; next cycle chk_ra=7 -> hazard=1. LSU transfer of rd=7 -> hazard=1 in the transfer cycle, hazard=0 the cycle after; chk_rb=0 never raises hazard.
- Set/clear collision: busy[9]=1, LSU transfer rd=9 while iss_load=1, iss_rd=9 -> busy[9] remains 1. Reset asserted mid-stream -> reg_wr=0 next cycle and every busy bit 0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_arbiter
//  Description : Shares the register file's single write port between the
//                ALU/execute stage and the load/store unit. Round-robin
//                arbitration with valid/ready handshakes, one registered
//                write stage in front of the register file, and a busy
//                scoreboard of destinations with outstanding loads that the
//                issue stage uses to stall on load-use hazards.
//
//  Ports       : clock, reset          - clock, synchronous active-high reset
//                alu_valid/alu_ready   - ALU writeback handshake
//                alu_rd/alu_data       - ALU destination and result
//                lsu_valid/lsu_ready   - LSU writeback handshake
//                lsu_rd/lsu_data       - load destination and result
//                iss_load/iss_rd       - load dispatched by issue, its rd
//                chk_ra/chk_rb         - issue-stage source registers
//                hazard                - a source is busy, issue must stall
//                wa/wda/reg_wr         - registered register file write port
//
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            iss_load,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   chk_ra,
    input  logic [AW-1:0]   chk_rb,
    output logic            hazard,
    output logic [AW-1:0]   wa,
    output logic [XLEN-1:0] wda,
    output logic            reg_wr
);

    localparam logic c_SRC_ALU = 1'b0;
    localparam logic c_SRC_LSU = 1'b1;

    logic            r_last_grant;
    logic            r_reg_wr;
    logic [AW-1:0]   r_wa;
    logic [XLEN-1:0] r_wda;
    logic [NREG-1:0] r_busy;

    logic            w_grant_alu;
    logic            w_grant_lsu;
    logic            w_xfer;
    logic [AW-1:0]   w_rd;
    logic [XLEN-1:0] w_data;
    logic [NREG-1:0] w_busy_next;

    // Round-robin grant. Under contention the source that did not win the
    // last transfer goes next. Nothing is granted while reset is held.
    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_lsu = 1'b0;
        if (!reset) begin
            if (alu_valid && lsu_valid) begin
                w_grant_lsu = (r_last_grant == c_SRC_ALU);
                w_grant_alu = (r_last_grant == c_SRC_LSU);
            end else begin
                w_grant_alu = alu_valid;
                w_grant_lsu = lsu_valid;
            end
        end
    end

    // A grant is only ever given to a valid source, so grant == transfer.
    assign w_xfer    = w_grant_alu | w_grant_lsu;
    assign w_rd      = w_grant_lsu ? lsu_rd   : alu_rd;
    assign w_data    = w_grant_lsu ? lsu_data : alu_data;
    assign alu_ready = w_grant_alu;
    assign lsu_ready = w_grant_lsu;

    // Clear is applied before set so a load dispatched to the same register
    // that is completing this cycle leaves the register busy.
    always_comb begin
        w_busy_next = r_busy;
        if (w_grant_lsu && (lsu_rd != '0)) begin
            w_busy_next[lsu_rd] = 1'b0;
        end
        if (iss_load && (iss_rd != '0)) begin
            w_busy_next[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= c_SRC_ALU;
            r_reg_wr     <= 1'b0;
            r_wa         <= '0;
            r_wda        <= '0;
            r_busy       <= '0;
        end else begin
            r_busy   <= w_busy_next;
            // Writes to x0 complete the handshake but never reach the file;
            // wa/wda keep their last values whenever no write is issued.
            r_reg_wr <= w_xfer && (w_rd != '0);
            if (w_xfer) begin
                r_last_grant <= w_grant_lsu ? c_SRC_LSU : c_SRC_ALU;
                if (w_rd != '0) begin
                    r_wa  <= w_rd;
                    r_wda <= w_data;
                end
            end
        end
    end

    // No bypass: a register stays hazardous through the cycle its load
    // data is being accepted.
    assign hazard = ((chk_ra != '0) && r_busy[chk_ra]) ||
                    ((chk_rb != '0) && r_busy[chk_rb]);

    assign wa     = r_wa;
    assign wda    = r_wda;
    assign reg_wr = r_reg_wr;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wb_arbiter
//  Description : Self-checking bench for rf_wb_arbiter. Directed scenarios
//                followed by randomized traffic, all checked against a
//                cycle-level behavioural model of the writeback port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clock = 1'b0;
    logic            reset;
    logic            alu_valid, alu_ready;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid, lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            iss_load;
    logic [AW-1:0]   iss_rd, chk_ra, chk_rb;
    logic            hazard;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wda;
    logic            reg_wr;

    rf_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_load(iss_load), .iss_rd(iss_rd), .chk_ra(chk_ra), .chk_rb(chk_rb),
        .hazard(hazard), .wa(wa), .wda(wda), .reg_wr(reg_wr)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who went last (0 = ALU, 1 = LSU), which registers
    // have loads in flight, and what the write port should show.
    int              m_last;
    bit              m_busy [NREG];
    bit              m_wr;
    logic [AW-1:0]   m_wa;
    logic [XLEN-1:0] m_wda;
    int              last_win;   // 0 none, 1 ALU, 2 LSU (model view)

    logic            seen_alu_rdy, seen_lsu_rdy, seen_haz;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 0;
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        m_wr  = 1'b0;
        m_wa  = '0;
        m_wda = '0;
    endtask

    // One clock cycle: drive inputs, check combinational outputs against the
    // model, advance the model, then check the registered write port.
    task automatic step(input bit rst,
                        input bit av, input logic [AW-1:0] ard, input logic [XLEN-1:0] adat,
                        input bit lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ldat,
                        input bit il, input logic [AW-1:0] ird,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        int win;
        bit exp_haz;
        @(negedge clock);
        reset = rst; alu_valid = av; alu_rd = ard; alu_data = adat;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
        iss_load = il; iss_rd = ird; chk_ra = ra; chk_rb = rb;
        #1;
        if (rst)            win = 0;
        else if (av && lv)  win = (m_last == 0) ? 2 : 1;
        else if (av)        win = 1;
        else if (lv)        win = 2;
        else                win = 0;
        exp_haz = ((ra != 0) && m_busy[ra]) || ((rb != 0) && m_busy[rb]);
        seen_alu_rdy = alu_ready;
        seen_lsu_rdy = lsu_ready;
        seen_haz     = hazard;
        chk("alu_ready", alu_ready, win == 1);
        chk("lsu_ready", lsu_ready, win == 2);
        chk("hazard", hazard, exp_haz);

        if (rst) begin
            model_reset();
        end else begin
            m_wr = 1'b0;
            if (win != 0) begin
                m_last = win - 1;
                if (win == 1 && ard != 0) begin m_wr = 1'b1; m_wa = ard; m_wda = adat; end
                if (win == 2 && lrd != 0) begin m_wr = 1'b1; m_wa = lrd; m_wda = ldat; end
                if (win == 2 && lrd != 0) m_busy[lrd] = 1'b0;
            end
            if (il && ird != 0) m_busy[ird] = 1'b1;
        end
        last_win = win;

        @(posedge clock);
        #1;
        chk("reg_wr", reg_wr, m_wr);
        chk("wa", wa, m_wa);
        chk("wda", wda, m_wda);
    endtask

    task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        step(0, 0, '0, '0, 0, '0, '0, 0, '0, ra, rb);
    endtask

    bit              a_v, l_v, r_rst, r_il;
    logic [AW-1:0]   a_rd, l_rd, r_ird, r_ra, r_rb;
    logic [XLEN-1:0] a_d, l_d;
    logic [AW-1:0]   seq_wa [4];
    logic [AW-1:0]   exp_seq [4];

    initial begin
        reset = 1'b1; alu_valid = 0; alu_rd = '0; alu_data = '0;
        lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
        iss_load = 0; iss_rd = '0; chk_ra = '0; chk_rb = '0;
        model_reset();
        last_win = 0;
        repeat (2) @(posedge clock);

        // Reset held with both sources requesting
        step(1, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, '0, 5'd3, 5'd4);
        step(1, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 5'd3, 5'd3, 5'd31);
        chk("rst_ready", {seen_alu_rdy, seen_lsu_rdy}, 2'b00);
        chk("rst_hazard", seen_haz, 1'b0);
        chk("rst_reg_wr", reg_wr, 1'b0);

        // Single ALU write
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 0, '0, '0, '0);
        chk("alu1_ready", seen_alu_rdy, 1'b1);
        chk("alu1_wr", reg_wr, 1'b1);
        chk("alu1_wa", wa, 5'd5);
        chk("alu1_wda", wda, 32'hDEADBEEF);
        idle('0, '0);
        chk("alu1_wr_off", reg_wr, 1'b0);

        // Contention straight after reset: LSU, ALU, LSU, ALU
        step(1, 0, '0, '0, 0, '0, '0, 0, '0, '0, '0);
        exp_seq[0] = 5'd2; exp_seq[1] = 5'd1; exp_seq[2] = 5'd2; exp_seq[3] = 5'd1;
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, '0, '0, '0);
            seq_wa[k] = wa;
            chk("cont_lsu_ready", seen_lsu_rdy, (k % 2) == 0);
        end
        for (int k = 0; k < 4; k++) chk("cont_wa_seq", seq_wa[k], exp_seq[k]);

        // Write to x0 from the LSU
        step(0, 0, '0, '0, 1, 5'd0, 32'h55, 0, '0, '0, '0);
        chk("x0_ready", seen_lsu_rdy, 1'b1);
        chk("x0_reg_wr", reg_wr, 1'b0);
        chk("x0_wa_hold", wa, 5'd1);

        // Load-use hazard on x7
        step(0, 0, '0, '0, 0, '0, '0, 1, 5'd7, '0, '0);
        idle(5'd7, 5'd0);
        chk("lu_haz_set", seen_haz, 1'b1);
        step(0, 0, '0, '0, 1, 5'd7, 32'h77, 0, '0, 5'd7, 5'd0);
        chk("lu_haz_clr_cycle", seen_haz, 1'b1);
        idle(5'd7, 5'd0);
        chk("lu_haz_after", seen_haz, 1'b0);
        step(0, 0, '0, '0, 0, '0, '0, 1, 5'd0, '0, '0);
        idle(5'd0, 5'd0);
        chk("x0_never_busy", seen_haz, 1'b0);

        // Set/clear collision on x9, then reset clears everything
        step(0, 0, '0, '0, 0, '0, '0, 1, 5'd9, '0, '0);
        step(0, 0, '0, '0, 1, 5'd9, 32'h99, 1, 5'd9, '0, '0);
        idle(5'd9, '0);
        chk("collide_busy", seen_haz, 1'b1);
        step(0, 1, 5'd12, 32'hC, 0, '0, '0, 1, 5'd20, '0, '0);
        step(1, 1, 5'd13, 32'hD, 0, '0, '0, 0, '0, '0, '0);
        chk("midrst_reg_wr", reg_wr, 1'b0);
        for (int r = 1; r < NREG; r++) begin
            idle(AW'(r), AW'(r));
            chk("midrst_busy", seen_haz, 1'b0);
        end

        // Randomized traffic with sources holding requests until accepted
        a_v = 0; l_v = 0; a_rd = '0; l_rd = '0; a_d = '0; l_d = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!a_v || last_win == 1) begin
                a_v = ($urandom_range(0, 3) != 0);
                a_rd = AW'($urandom_range(0, 7)); a_d = $urandom;
            end
            if (!l_v || last_win == 2) begin
                l_v = ($urandom_range(0, 2) != 0);
                l_rd = AW'($urandom_range(0, 7)); l_d = $urandom;
            end
            r_rst = ($urandom_range(0, 99) == 0);
            r_il  = ($urandom_range(0, 2) == 0);
            r_ird = AW'($urandom_range(0, 7));
            r_ra  = AW'($urandom_range(0, 7));
            r_rb  = AW'($urandom_range(0, 7));
            step(r_rst, a_v, a_rd, a_d, l_v, l_rd, l_d, r_il, r_ird, r_ra, r_rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
